ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexed scan controller for a 4-digit, common-anode, active-low seven-segment display. It shares one combinational BCD-to-segment decoder across all four digits. Each cycle it selects one digit's BCD value for the decoder and takes the decoded segment pattern back. It then applies leading-zero blanking, decimal-point insertion, invalid-digit masking and inter-digit ghosting guard, and registers the anode enables and segment pattern for the board pins. It sits between the lab datapath's digit registers and the SSD pins.

## Interface

Parameters:
- SLOT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- GUARD_CYCLES, 1000: trailing cycles of each slot with all anodes off; must be < SLOT_CYCLES.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- digits  in  16  four BCD digits; digit i at [4i+3:4i], digit 3 leftmost.
- dp_mask  in  4  bit i = 1 lights the decimal point of digit i.
- lz_blank  in  1  1 = blank leading zeros.
- bcd_sel  out  4  BCD value to the shared decoder (combinational from registers).
- segs_in  in  8  decoder result: {a,b,c,d,e,f,g,dp}, active-low, bit0 = dp.
- ssd_ctl  out  4  anode enables, active-low, bit i = digit i (registered).
- segs  out  8  segment pins, same format as segs_in (registered).
- frame_tick  out  1  one-cycle pulse at each frame boundary (registered).

## Operation

- **State:**
  - cnt: 0..SLOT_CYCLES-1.
  - idx: 0..3.
  - shadow_digits[15:0], shadow_dp[3:0], shadow_lz.
- **en = 0:**
  - cnt and idx are cleared to 0.
  - Shadow registers load digits, dp_mask and lz_blank every cycle.
  - Output registers load ssd_ctl = 4'b1111, segs = 8'hFF, frame_tick = 0.
- **en = 1, counting:**
  - cnt increments each cycle.
  - At cnt = SLOT_CYCLES-1, cnt wraps to 0 and idx increments mod 4 (0→1→2→3→0).
- **Frame boundary:** on the edge where cnt = SLOT_CYCLES-1 and idx = 3:
  - Shadow registers load the current inputs.
  - frame_tick is registered high for that one cycle.
  - Input changes at any other time are invisible until the next boundary (no tearing).
- **Decoder select:** bcd_sel = shadow_digits[4·idx+3 : 4·idx].
- **Per-cycle output selection**, by priority, for the current idx:
  1. Guard: if cnt ≥ SLOT_CYCLES-GUARD_CYCLES, then ssd_ctl = 4'b1111 and segs = 8'hFF.
  2. Leading-zero blank: if shadow_lz = 1, idx ≠ 0, digit idx = 0 and every higher digit = 0, then ssd_ctl = 4'b1111 and segs = 8'hFF. Digit 0 is never blanked.
  3. Invalid digit: if digit idx > 9, ssd_ctl drives only bit idx low and segs = 8'b11111101 (dash, segment g only). segs_in is ignored.
  4. Normal: ssd_ctl drives only bit idx low; segs[7:1] = segs_in[7:1] and segs[0] = segs_in[0] & ~shadow_dp[idx].
- In cases 1 and 2 the decimal point is suppressed. In case 3 the dp is still applied to segs[0].
- **Reset (rst_n low, asynchronous):**
  - cnt = 0, idx = 0, shadow registers = 0.
  - ssd_ctl = 4'b1111, segs = 8'hFF, frame_tick = 0.
  - bcd_sel therefore reads 4'h0.

## Timing

- The output registers load from (cnt, idx) of the same cycle, so the pins lag internal state by exactly one cycle. ssd_ctl and segs always change on the same edge.
- With en going high with cnt = 0, idx = 0, the first edge with en = 1 registers slot 0: ssd_ctl = 4'b1110.
- Per slot, the digit is lit for SLOT_CYCLES-GUARD_CYCLES cycles, then dark for GUARD_CYCLES cycles.
- Frame period is 4·SLOT_CYCLES cycles. frame_tick is high on the same cycle the pins show slot 3's last guard cycle.
- New shadow values drive bcd_sel on the cycle after the frame boundary edge; the first slot-0 pin output of the new frame uses them.
- en falling: the next edge blanks the outputs. en rising later restarts at slot 0, cnt 0.
- rst_n assertion mid-slot forces the outputs off immediately, without waiting for a clock. Scanning restarts at slot 0 on the first edge after release with en = 1.

## Test plan

All scenarios use SLOT_CYCLES = 8, GUARD_CYCLES = 2, and a behavioural decoder model (0→00000011 … 9→00001001, >9→00000000).

1. **Reset:** hold rst_n = 0 → ssd_ctl = 1111, segs = FF, frame_tick = 0, bcd_sel = 0. Pulse rst_n low asynchronously mid-slot 2 → outputs go off before the next clk edge.
2. **Basic scan:** digits = 16'h1234, dp_mask = 0, lz_blank = 0, en = 1.
   - ssd_ctl: 1110×6, 1111×2, 1101×6, 1111×2, 1011×6, 1111×2, 0111×6, 1111×2, then repeats.
   - segs during lit cycles: 10011001, 00001101, 00100101, 10011111.
   - frame_tick pulses every 32 cycles.
3. **Snapshot:** change digits 1234→5678 at cycle 10 of a frame → remainder of the frame still shows 3,2,1. The next frame shows 8,7,6,5 starting the cycle after frame_tick.
4. **Leading-zero blank:** lz_blank = 1.
   - digits = 16'h0070 → digits 3 and 2 stay dark (1111/FF), digit 1 shows 00011111, digit 0 shows 00000011.
   - digits = 16'h0000 → only digit 0 lit.
5. **dp and invalid digit:** digits = 16'h0A00, dp_mask = 4'b0100 → digit 2 shows 11111100 (dash plus dp), all other digits have segs[0] = 1.
6. **Enable toggle:** drop en during slot 1 → next edge ssd_ctl = 1111, segs = FF. Re-raise en → next edge ssd_ctl = 1110, and the shadow holds the inputs present while en was low.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Shares one external BCD decoder and registers the anode/segment pins.
module ssd_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  bcd_sel,
  input  logic [7:0]  segs_in,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  segs,
  output logic        frame_tick
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW:0] GSTART = (CW+1)'(SLOT_CYCLES - GUARD_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_dp;
  logic          sh_lz;

  logic          last;
  logic          guard;
  logic          lz_hit;
  logic          dp_bit;
  logic [3:0]    onehot_n;
  logic [3:0]    ctl_d;
  logic [7:0]    segs_d;
  logic          d1z, d2z, d3z;

  assign last  = (cnt == LAST);
  assign guard = (GUARD_CYCLES > 0) && ({1'b0, cnt} >= GSTART);
  assign d1z   = (sh_digits[7:4] == 4'd0);
  assign d2z   = (sh_digits[11:8] == 4'd0);
  assign d3z   = (sh_digits[15:12] == 4'd0);
  assign dp_bit   = sh_dp[idx];
  assign onehot_n = ~(4'b0001 << idx);

  always_comb begin
    bcd_sel = 4'd0;
    lz_hit  = 1'b0;
    unique case (idx)
      2'd0: begin
        bcd_sel = sh_digits[3:0];
        lz_hit  = 1'b0;
      end
      2'd1: begin
        bcd_sel = sh_digits[7:4];
        lz_hit  = d1z & d2z & d3z;
      end
      2'd2: begin
        bcd_sel = sh_digits[11:8];
        lz_hit  = d2z & d3z;
      end
      2'd3: begin
        bcd_sel = sh_digits[15:12];
        lz_hit  = d3z;
      end
    endcase
  end

  // priority: guard, leading-zero blank, invalid dash, normal
  always_comb begin
    ctl_d  = 4'b1111;
    segs_d = 8'hFF;
    if (guard || (sh_lz && lz_hit)) begin
      ctl_d  = 4'b1111;
      segs_d = 8'hFF;
    end else if (bcd_sel > 4'd9) begin
      ctl_d  = onehot_n;
      segs_d = {7'b1111110, ~dp_bit};
    end else begin
      ctl_d  = onehot_n;
      segs_d = {segs_in[7:1], segs_in[0] & ~dp_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh_digits  <= 16'd0;
      sh_dp      <= 4'd0;
      sh_lz      <= 1'b0;
      ssd_ctl    <= 4'b1111;
      segs       <= 8'hFF;
      frame_tick <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh_digits  <= digits;
      sh_dp      <= dp_mask;
      sh_lz      <= lz_blank;
      ssd_ctl    <= 4'b1111;
      segs       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      ssd_ctl    <= ctl_d;
      segs       <= segs_d;
      frame_tick <= last && (idx == 2'd3);
      if (last) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sh_digits <= digits;
          sh_dp     <= dp_mask;
          sh_lz     <= lz_blank;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with a table decoder on bcd_sel.
// Expected pin values are queued per cycle and popped by a monitor.
module tb_ssd_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int LIT   = SLOT - GUARD;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [3:0]  bcd_sel;
  logic [7:0]  segs_in;
  logic [3:0]  ssd_ctl;
  logic [7:0]  segs;
  logic        frame_tick;

  typedef struct {
    logic [3:0] ctl;
    logic [7:0] sg;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int total;
  int bad;
  int popped;

  ssd_scan_ctrl #(
    .SLOT_CYCLES(SLOT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digits(digits),
    .dp_mask(dp_mask),
    .lz_blank(lz_blank),
    .bcd_sel(bcd_sel),
    .segs_in(segs_in),
    .ssd_ctl(ssd_ctl),
    .segs(segs),
    .frame_tick(frame_tick)
  );

  always_comb begin
    segs_in = 8'b00000000;
    case (bcd_sel)
      4'd0: segs_in = 8'b00000011;
      4'd1: segs_in = 8'b10011111;
      4'd2: segs_in = 8'b00100101;
      4'd3: segs_in = 8'b00001101;
      4'd4: segs_in = 8'b10011001;
      4'd5: segs_in = 8'b01001001;
      4'd6: segs_in = 8'b01000001;
      4'd7: segs_in = 8'b00011111;
      4'd8: segs_in = 8'b00000001;
      4'd9: segs_in = 8'b00001001;
      default: segs_in = 8'b00000000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  // monitor: one queued expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("ctl#%0d", popped), 32'(ssd_ctl), 32'(e.ctl));
        chk($sformatf("segs#%0d", popped), 32'(segs), 32'(e.sg));
        chk($sformatf("ft#%0d", popped), 32'(frame_tick), 32'(e.ft));
        popped++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_blank();
    exp_t e;
    e.ctl = 4'b1111;
    e.sg  = 8'hFF;
    e.ft  = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_slot(input int s, input logic lit,
                           input logic [7:0] sg, input int n);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << s;
    for (int c = 0; c < n; c++) begin
      if (lit && c < LIT) begin
        e.ctl = ~oh;
        e.sg  = sg;
      end else begin
        e.ctl = 4'b1111;
        e.sg  = 8'hFF;
      end
      e.ft = (s == 3) && (c == SLOT - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [3:0] lit,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push_slot(0, lit[0], s0, SLOT);
    push_slot(1, lit[1], s1, SLOT);
    push_slot(2, lit[2], s2, SLOT);
    push_slot(3, lit[3], s3, SLOT);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    popped   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    digits   = 16'h0000;
    dp_mask  = 4'd0;
    lz_blank = 1'b0;

    run(3);
    chk("rst_ctl", 32'(ssd_ctl), 32'hF);
    chk("rst_segs", 32'(segs), 32'hFF);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    chk("rst_bcd", 32'(bcd_sel), 32'h0);

    rst_n  = 1'b1;
    digits = 16'h1234;
    push_blank();
    step();

    // basic scan, two frames
    en = 1'b1;
    push_frame(4'b1111, 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);
    push_frame(4'b1111, 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);
    run(2 * 4 * SLOT);

    // snapshot: input change mid-frame waits for the boundary
    push_frame(4'b1111, 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);
    push_frame(4'b1111, 8'b00000001, 8'b00011111, 8'b01000001, 8'b01001001);
    run(10);
    digits = 16'h5678;
    run(4 * SLOT - 10 + 4 * SLOT);

    // leading-zero blank 0070
    en       = 1'b0;
    lz_blank = 1'b1;
    digits   = 16'h0070;
    push_blank();
    step();
    en = 1'b1;
    push_frame(4'b0011, 8'b00000011, 8'b00011111, 8'hFF, 8'hFF);
    run(4 * SLOT);

    // leading-zero blank 0000
    en     = 1'b0;
    digits = 16'h0000;
    push_blank();
    step();
    en = 1'b1;
    push_frame(4'b0001, 8'b00000011, 8'hFF, 8'hFF, 8'hFF);
    run(4 * SLOT);

    // dp and invalid digit
    en       = 1'b0;
    lz_blank = 1'b0;
    digits   = 16'h0A00;
    dp_mask  = 4'b0100;
    push_blank();
    step();
    en = 1'b1;
    push_frame(4'b1111, 8'b00000011, 8'b00000011, 8'b11111100, 8'b00000011);
    run(4 * SLOT);

    // enable drop during slot 1
    push_slot(0, 1'b1, 8'b00000011, SLOT);
    push_slot(1, 1'b1, 8'b00000011, 3);
    run(SLOT + 3);
    en       = 1'b0;
    digits   = 16'h0859;
    dp_mask  = 4'b0001;
    lz_blank = 1'b1;
    push_blank();
    step();
    en = 1'b1;
    push_frame(4'b0111, 8'b00001000, 8'b01001001, 8'b00000001, 8'hFF);
    run(4 * SLOT);

    // async reset mid slot 2
    push_slot(0, 1'b1, 8'b00001000, SLOT);
    push_slot(1, 1'b1, 8'b01001001, SLOT);
    push_slot(2, 1'b1, 8'b00000001, 3);
    run(2 * SLOT + 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'(ssd_ctl), 32'hF);
    chk("arst_segs", 32'(segs), 32'hFF);
    chk("arst_ft", 32'(frame_tick), 32'h0);
    chk("arst_bcd", 32'(bcd_sel), 32'h0);
    step();
    rst_n = 1'b1;
    push_frame(4'b1111, 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
    run(4 * SLOT);

    run(2);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
